// File: rtl/div_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : div_pkg
//  Description : Shared types and constants for the sequential divider:
//                FSM state encoding, default operand width and iteration
//                counter width.
//  Revision    : 1.0  initial release
// ============================================================================
package div_pkg;

    localparam int DIV_WIDTH = 8;

    // Counter must hold WIDTH-1; guard the degenerate 1-bit case.
    function automatic int div_cnt_w(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

    localparam int DIV_CNT_W = div_cnt_w(DIV_WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/seq_divider_8bit_if.sv
`default_nettype none
// ============================================================================
//  Module      : seq_divider_8bit_if
//  Description : Start/done handshake and operand/result bus between the
//                control FSM (master) and the sequential divider (slave).
//  Revision    : 1.0  initial release
// ============================================================================
interface seq_divider_8bit_if
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) ();

    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_zero
    );

endinterface
`default_nettype wire

// File: rtl/borrow_lookahead_sub.sv
`default_nettype none
// ============================================================================
//  Module      : borrow_lookahead_sub
//  Description : Unsigned subtractor diff = a - b built from 4-bit
//                borrow-lookahead groups; borrows ripple between groups.
//                bout=1 means a < b.
//  Revision    : 1.0  initial release
// ============================================================================
module borrow_lookahead_sub #(
    parameter int W = 9
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] diff,
    output logic         bout
);

    localparam int NGRP = (W + 3) / 4;

    logic [W-1:0] w_g;   // borrow generate: this bit borrows on its own
    logic [W-1:0] w_p;   // borrow propagate: an incoming borrow passes through

    assign w_g = ~a & b;
    assign w_p = ~(a ^ b);

    for (genvar gi = 0; gi < NGRP; gi++) begin : g_grp
        localparam int LO = 4 * gi;
        localparam int GW = ((W - LO) > 4) ? 4 : (W - LO);

        logic          w_bin;
        logic          w_bout;
        logic [GW:0]   w_bor;

        if (gi == 0) begin : g_first
            assign w_bin = 1'b0;
        end else begin : g_chain
            assign w_bin = g_grp[gi-1].w_bout;
        end

        // Flat sum-of-products borrow into each bit from the group borrow-in.
        always_comb begin
            logic v_sop;
            logic v_prod;
            w_bor    = '0;
            w_bor[0] = w_bin;
            for (int j = 1; j <= GW; j++) begin
                v_sop = 1'b0;
                for (int k = 0; k < j; k++) begin
                    v_prod = w_g[LO+k];
                    for (int m = k + 1; m < j; m++) begin
                        v_prod = v_prod & w_p[LO+m];
                    end
                    v_sop = v_sop | v_prod;
                end
                v_prod = w_bin;
                for (int m = 0; m < j; m++) begin
                    v_prod = v_prod & w_p[LO+m];
                end
                w_bor[j] = v_sop | v_prod;
            end
        end

        assign w_bout         = w_bor[GW];
        assign diff[LO +: GW] = a[LO +: GW] ^ b[LO +: GW] ^ w_bor[GW-1:0];
    end

    assign bout = g_grp[NGRP-1].w_bout;

endmodule
`default_nettype wire

// File: rtl/seq_divider_8bit.sv
`default_nettype none
// ============================================================================
//  Module      : seq_divider_8bit
//  Description : Iterative restoring divider, one quotient bit per clock.
//                start accepted in IDLE or DONE; WIDTH CALC cycles; one-cycle
//                done pulse. Optional macro DIV_ZERO_DETECT_EN short-cuts a
//                zero divisor straight to DONE and raises div_zero.
//  Revision    : 1.0  initial release
// ============================================================================
module seq_divider_8bit
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  wire logic           clk,
    input  wire logic           rst,
    seq_divider_8bit_if.slave   bus
);

    localparam int CNT_W = div_cnt_w(WIDTH);

    state_t             state_q,     state_d;
    logic [CNT_W-1:0]   cnt_q,       cnt_d;
    logic [WIDTH-1:0]   dvd_q,       dvd_d;      // dividend out / quotient in
    logic [WIDTH-1:0]   dvs_q,       dvs_d;
    logic [WIDTH:0]     prem_q,      prem_d;     // partial remainder
    logic [WIDTH-1:0]   quotient_q,  quotient_d;
    logic [WIDTH-1:0]   remainder_q, remainder_d;
    logic               div_zero_q,  div_zero_d;

    logic [WIDTH:0]     w_trial_a;
    logic [WIDTH:0]     w_trial_b;
    logic [WIDTH:0]     w_diff;
    logic               w_borrow;

    // Shifted partial remainder with the next dividend bit, against divisor.
    assign w_trial_a = {prem_q[WIDTH-1:0], dvd_q[WIDTH-1]};
    assign w_trial_b = {1'b0, dvs_q};

    borrow_lookahead_sub #(
        .W (WIDTH + 1)
    ) u_sub (
        .a    (w_trial_a),
        .b    (w_trial_b),
        .diff (w_diff),
        .bout (w_borrow)
    );

    // Next-state and datapath update for the IDLE/CALC/DONE sequencer.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        dvd_d       = dvd_q;
        dvs_d       = dvs_q;
        prem_d      = prem_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        div_zero_d  = div_zero_q;

        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (bus.start) begin
                    dvs_d      = bus.divisor;
                    dvd_d      = bus.dividend;
                    prem_d     = '0;
                    cnt_d      = CNT_W'(WIDTH - 1);
                    div_zero_d = 1'b0;
                    state_d    = CALC;
`ifdef DIV_ZERO_DETECT_EN
                    if (bus.divisor == '0) begin
                        quotient_d  = '1;
                        remainder_d = bus.dividend;
                        div_zero_d  = 1'b1;
                        state_d     = DONE;
                    end
`endif
                end
            end

            CALC: begin
                // Restore on borrow by keeping the shifted value.
                prem_d = w_borrow ? w_trial_a : w_diff;
                dvd_d  = {dvd_q[WIDTH-2:0], ~w_borrow};
                if (cnt_q == '0) begin
                    quotient_d  = dvd_d;
                    remainder_d = prem_d[WIDTH-1:0];
                    state_d     = DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            dvd_q       <= '0;
            dvs_q       <= '0;
            prem_q      <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            div_zero_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            dvd_q       <= dvd_d;
            dvs_q       <= dvs_d;
            prem_q      <= prem_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            div_zero_q  <= div_zero_d;
        end
    end

    assign bus.busy      = (state_q == CALC);
    assign bus.done      = (state_q == DONE);
    assign bus.quotient  = quotient_q;
    assign bus.remainder = remainder_q;
    assign bus.div_zero  = div_zero_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_divider_8bit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq_divider_8bit
//  Description : Directed self-checking bench for seq_divider_8bit
//                (honours DIV_ZERO_DETECT_EN).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_seq_divider_8bit;
    import div_pkg::*;

    localparam int W = DIV_WIDTH;

`ifdef DIV_ZERO_DETECT_EN
    localparam int   DZ_LAT  = 0;
    localparam logic DZ_FLAG = 1'b1;
`else
    localparam int   DZ_LAT  = W;
    localparam logic DZ_FLAG = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    seq_divider_8bit_if #(.WIDTH(W)) bus ();

    seq_divider_8bit #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one operation and check latency, busy span and results.
    task automatic run_div(input string tag, input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] eq, input logic [7:0] er,
                           input logic edz, input int elat);
        int n;
        int nb;
        bus.start    = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        step();
        bus.start = 1'b0;
        n  = 0;
        nb = 0;
        while (bus.done !== 1'b1 && n < 20) begin
            if (bus.busy === 1'b1) nb++;
            step();
            n++;
        end
        check({tag, "_latency"},   n,             elat);
        check({tag, "_busy_span"}, nb,            elat);
        check({tag, "_busy_done"}, bus.busy,      1'b0);
        check({tag, "_quot"},      bus.quotient,  eq);
        check({tag, "_rem"},       bus.remainder, er);
        check({tag, "_dz"},        bus.div_zero,  edz);
        step();
        check({tag, "_done_pulse"}, bus.done,     1'b0);
        check({tag, "_quot_hold"},  bus.quotient, eq);
    endtask

    initial begin
        int n;

        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        step();
        step();
        check("rst_busy", bus.busy,      1'b0);
        check("rst_done", bus.done,      1'b0);
        check("rst_quot", bus.quotient,  8'd0);
        check("rst_rem",  bus.remainder, 8'd0);
        check("rst_dz",   bus.div_zero,  1'b0);
        rst = 1'b0;
        step();

        run_div("basic",   8'd200, 8'd7,   8'd28,  8'd4, 1'b0, W);
        run_div("max_by1", 8'd255, 8'd1,   8'd255, 8'd0, 1'b0, W);
        run_div("small",   8'd5,   8'd9,   8'd0,   8'd5, 1'b0, W);
        run_div("self",    8'd255, 8'd255, 8'd1,   8'd0, 1'b0, W);

        // Back-to-back: start held through the first DONE cycle.
        bus.start    = 1'b1;
        bus.dividend = 8'd100;
        bus.divisor  = 8'd10;
        step();
        bus.dividend = 8'd77;
        bus.divisor  = 8'd8;
        n = 0;
        while (bus.done !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        check("b2b1_latency", n,             W);
        check("b2b1_quot",    bus.quotient,  8'd10);
        check("b2b1_rem",     bus.remainder, 8'd0);
        step();
        bus.start = 1'b0;
        check("b2b2_no_bubble", bus.busy, 1'b1);
        check("b2b2_not_done",  bus.done, 1'b0);
        n = 0;
        while (bus.done !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        check("b2b2_latency", n,             W);
        check("b2b2_quot",    bus.quotient,  8'd9);
        check("b2b2_rem",     bus.remainder, 8'd5);
        step();

        // start reasserted mid-CALC must be ignored.
        bus.start    = 1'b1;
        bus.dividend = 8'd200;
        bus.divisor  = 8'd7;
        step();
        bus.start = 1'b0;
        n = 0;
        step();
        n++;
        step();
        n++;
        bus.start    = 1'b1;
        bus.dividend = 8'd255;
        bus.divisor  = 8'd1;
        step();
        n++;
        bus.start = 1'b0;
        while (bus.done !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        check("busy_start_latency", n,             W);
        check("busy_start_quot",    bus.quotient,  8'd28);
        check("busy_start_rem",     bus.remainder, 8'd4);
        step();

        // Reset asserted during the 4th CALC cycle.
        bus.start    = 1'b1;
        bus.dividend = 8'd200;
        bus.divisor  = 8'd7;
        step();
        bus.start = 1'b0;
        step();
        step();
        step();
        check("pre_rst_busy", bus.busy, 1'b1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst_busy", bus.busy,      1'b0);
        check("midrst_done", bus.done,      1'b0);
        check("midrst_quot", bus.quotient,  8'd0);
        check("midrst_rem",  bus.remainder, 8'd0);
        check("midrst_dz",   bus.div_zero,  1'b0);
        step();
        check("midrst_idle_done", bus.done, 1'b0);
        check("midrst_idle_busy", bus.busy, 1'b0);

        run_div("after_rst", 8'd50,  8'd3, 8'd16,  8'd2,   1'b0,    W);
        run_div("div0",      8'd100, 8'd0, 8'd255, 8'd100, DZ_FLAG, DZ_LAT);
        run_div("post_div0", 8'd13,  8'd4, 8'd3,   8'd1,   1'b0,    W);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seq_divider_8bit.md
# seq_divider_8bit

Iterative restoring divider for the 8-bit datapath: the inverse operation of the lookahead adder/multiplier chain. It produces an unsigned quotient and remainder one bit per clock. Each trial subtraction is done in a borrow-lookahead subtractor, the borrow-domain counterpart of the 4-bit carry-lookahead block. It sits beside the multiplier as the arithmetic unit's divide path, with a start/done handshake toward the control FSM.

## Interface
- WIDTH, 8, operand width; quotient and remainder are WIDTH bits.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  request; sampled only when busy=0.
- dividend  in  WIDTH  unsigned numerator; captured on an accepted start.
- divisor  in  WIDTH  unsigned denominator; captured on an accepted start.
- busy  out  1  high while in CALC.
- done  out  1  single-cycle pulse; quotient and remainder are valid in this cycle.
- quotient  out  WIDTH  result; holds its value until the next accepted start.
- remainder  out  WIDTH  result; holds its value until the next accepted start.
- div_zero  out  1  divisor==0 flag; valid with done.

## Operation
- States:
  - IDLE: accepts start.
  - CALC: runs WIDTH iterations.
  - DONE: one cycle with done=1, then IDLE.
  - start is accepted in IDLE and in DONE (back-to-back issue). In CALC, start is ignored.
- On an accepted start:
  - Latch the divisor.
  - Load the dividend into the shift register.
  - Clear the partial remainder (WIDTH+1 bits).
  - Set the iteration counter to WIDTH-1.
  - Clear div_zero.
- Each CALC cycle:
  - Shift the partial remainder left one bit, taking in the dividend MSB; shift the dividend left.
  - Compute the trial difference, partial remainder minus {0,divisor}, in the subtractor.
  - If there is no borrow, commit the difference and shift quotient bit 1 in. Otherwise keep the partial remainder and shift 0 in.
- When the counter reaches 0, the last iteration commits and the state moves to DONE.
- Arithmetic is unsigned, with no overflow possible. The final remainder is the low WIDTH bits of the partial remainder, and remainder < divisor always holds when divisor≠0.
- rst in any state: go to IDLE and set every output register to 0. An in-flight operation is discarded.

## Timing
- Reset values: busy=0, done=0, quotient=0, remainder=0, div_zero=0.
- start is sampled at edge k (state IDLE or DONE).
- busy=1 for the cycles following edges k … k+WIDTH-1.
- done=1 for the cycle following edge k+WIDTH, which is WIDTH+1 cycles after the start cycle (9 for WIDTH=8).
- quotient and remainder update at edge k+WIDTH together with done, then are stable.
- done never asserts in the same cycle as busy.
- A start accepted during the DONE cycle gives busy=1 in the next cycle, with no idle bubble.

## Configuration
- DIV_ZERO_DETECT_EN defined:
  - A start with divisor==0 goes directly IDLE/DONE→DONE.
  - done is asserted the cycle after the start cycle, with quotient={WIDTH{1}}, remainder=dividend, div_zero=1.
- DIV_ZERO_DETECT_EN undefined:
  - No special case. A divide by zero runs the full WIDTH iterations and naturally yields quotient={WIDTH{1}}, remainder=dividend.
  - div_zero is tied to 0.

## Structure
- Package div_pkg holds:
  - the state enum (IDLE, CALC, DONE);
  - the default WIDTH constant;
  - the counter width, clog2(WIDTH).
- Sub-module borrow_lookahead_sub:
  - Parameterised width (WIDTH+1 here).
  - Uses per-bit borrow-generate g=~a&b and borrow-propagate p=~(a^b).
  - Lookahead borrow groups of 4 bits, rippled between groups.
  - Outputs the difference and bout; bout=1 means borrow, i.e. a<b.

## Test plan
- Basic divide: dividend=200, divisor=7, start for 1 cycle → done 9 cycles later, quotient=28, remainder=4, div_zero=0.
- Full-range extremes:
  - 255/1 → 255 r0.
  - 5/9 → 0 r5.
  - 255/255 → 1 r0.
- Back-to-back: start held high through the first DONE cycle with 100/10, then 77/8 → first done gives 10 r0; the second done follows 9 cycles later with 9 r5.
- Start while busy: reassert start with different operands mid-CALC → ignored; the result matches the original operands.
- Reset mid-operation: assert rst during the 4th CALC cycle → the next cycle has all outputs 0 and busy=0; a subsequent start of 50/3 gives 16 r2.
- Divide by zero: 100/0.
  - With DIV_ZERO_DETECT_EN: done the cycle after start, quotient=255, remainder=100, div_zero=1.
  - Without it: done after 9 cycles, same quotient/remainder, div_zero=0.
